// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 LED chain drivers.
package ws2812_pkg;

    // Frame driver states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_LATCH = 3'd4
    } state_t;

    // Default bit timing for a 40 MHz clock (25 ns per cycle)
    localparam int DEF_T0H_CYC   = 16;
    localparam int DEF_T1H_CYC   = 32;
    localparam int DEF_T0L_CYC   = 34;
    localparam int DEF_T1L_CYC   = 18;
    localparam int DEF_RESET_CYC = 2000;

    // Width of a phase counter able to hold the longest phase length
    function automatic int ws2812_cnt_width(input int t0h, input int t1h, input int t0l,
                                            input int t1l, input int rst);
        int m;
        m = t0h;
        m = (t1h > m) ? t1h : m;
        m = (t0l > m) ? t0l : m;
        m = (t1l > m) ? t1l : m;
        m = (rst > m) ? rst : m;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Loadable down-counter: times one phase of the LED waveform and raises
// 'expired' during the final cycle of that phase, so the owner can switch
// phase on the very next edge without losing a cycle.
module ws2812_bit_timer #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             srst,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             expired
);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(32'd2);

    logic [CNT_W-1:0] count_r;
    logic             expired_r;

    // Count the loaded phase down; flag the cycle in which one cycle remains
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r   <= CNT_ZERO;
            expired_r <= 1'b0;
        end else if (srst) begin
            count_r   <= CNT_ZERO;
            expired_r <= 1'b0;
        end else if (load) begin
            count_r   <= len;
            expired_r <= (len == CNT_ONE);
        end else if (count_r != CNT_ZERO) begin
            count_r   <= count_r - CNT_ONE;
            expired_r <= (count_r == CNT_TWO);
        end else begin
            expired_r <= 1'b0;
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/ws2812_frame_driver.sv
// WS2812 chain driver: streams a whole frame of NUM_LEDS pixels as one
// gapless bitstream, pulling pixels through valid/ready with a one-pixel
// prefetch buffer, then holds the line low for the latch period.
module ws2812_frame_driver
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = 64,
    parameter int BITS_PER_LED = 24,
    parameter int T0H_CYC      = DEF_T0H_CYC,
    parameter int T1H_CYC      = DEF_T1H_CYC,
    parameter int T0L_CYC      = DEF_T0L_CYC,
    parameter int T1L_CYC      = DEF_T1L_CYC,
    parameter int RESET_CYC    = DEF_RESET_CYC,
    parameter int MSB_FIRST    = 1
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic                                            start,
    input  logic [BITS_PER_LED-1:0]                         pix_data,
    input  logic                                            pix_valid,
    output logic                                            pix_ready,
    output logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0] pix_index,
    output logic                                            datastream,
    output logic                                            busy,
    output logic                                            frame_done,
    output logic                                            underrun
);

    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int ACC_W = $clog2(NUM_LEDS + 1);
    localparam int BIT_W = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
    localparam int CNT_W = ws2812_cnt_width(T0H_CYC, T1H_CYC, T0L_CYC, T1L_CYC, RESET_CYC);

    localparam logic [ACC_W-1:0]        ACC_ZERO  = ACC_W'(32'd0);
    localparam logic [ACC_W-1:0]        ACC_ONE   = ACC_W'(32'd1);
    localparam logic [ACC_W-1:0]        ACC_FULL  = ACC_W'(NUM_LEDS);
    localparam logic [IDX_W-1:0]        IDX_ZERO  = IDX_W'(32'd0);
    localparam logic [IDX_W-1:0]        IDX_LAST  = IDX_W'(NUM_LEDS - 1);
    localparam logic [BIT_W-1:0]        BIT_ZERO  = BIT_W'(32'd0);
    localparam logic [BIT_W-1:0]        BIT_ONE   = BIT_W'(32'd1);
    localparam logic [BIT_W-1:0]        BIT_LAST  = BIT_W'(BITS_PER_LED - 1);
    localparam logic [CNT_W-1:0]        CNT_ZERO  = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0]        LEN_T0H   = CNT_W'(T0H_CYC);
    localparam logic [CNT_W-1:0]        LEN_T1H   = CNT_W'(T1H_CYC);
    localparam logic [CNT_W-1:0]        LEN_T0L   = CNT_W'(T0L_CYC);
    localparam logic [CNT_W-1:0]        LEN_T1L   = CNT_W'(T1L_CYC);
    localparam logic [CNT_W-1:0]        LEN_LATCH = CNT_W'(RESET_CYC);
    localparam logic [BITS_PER_LED-1:0] WORD_ZERO = {BITS_PER_LED{1'b0}};

    if (T0H_CYC < 1 || T1H_CYC < 1 || T0L_CYC < 1 || T1L_CYC < 1 || RESET_CYC < 1) begin : g_bad_timing
        $error("ws2812_frame_driver: every timing parameter must be at least 1");
    end
    if (NUM_LEDS < 1 || BITS_PER_LED < 1) begin : g_bad_size
        $error("ws2812_frame_driver: NUM_LEDS and BITS_PER_LED must be at least 1");
    end

    // Bit that goes on the wire first for a given word
    function automatic logic first_bit(input logic [BITS_PER_LED-1:0] word);
        logic b;
        if (MSB_FIRST != 0) b = word[BITS_PER_LED-1];
        else                b = word[0];
        return b;
    endfunction

    // Word with the bit just sent removed
    function automatic logic [BITS_PER_LED-1:0] shift_out(input logic [BITS_PER_LED-1:0] word);
        logic [BITS_PER_LED-1:0] w;
        if (MSB_FIRST != 0) w = word << 1'b1;
        else                w = word >> 1'b1;
        return w;
    endfunction

    function automatic logic [CNT_W-1:0] high_len(input logic b);
        logic [CNT_W-1:0] l;
        if (b) l = LEN_T1H;
        else   l = LEN_T0H;
        return l;
    endfunction

    function automatic logic [CNT_W-1:0] low_len(input logic b);
        logic [CNT_W-1:0] l;
        if (b) l = LEN_T1L;
        else   l = LEN_T0L;
        return l;
    endfunction

    // Index of the next pixel to request once 'acc' pixels have been taken
    function automatic logic [IDX_W-1:0] index_after(input logic [ACC_W-1:0] acc);
        logic [IDX_W-1:0] idx;
        if ((acc + ACC_ONE) < ACC_FULL) idx = IDX_W'(acc + ACC_ONE);
        else                            idx = IDX_LAST;
        return idx;
    endfunction

    state_t                  state_r;
    logic [BITS_PER_LED-1:0] shift_r;
    logic [BITS_PER_LED-1:0] buf_r;
    logic                    buf_full_r;
    logic [BIT_W-1:0]        bit_cnt_r;
    logic [ACC_W-1:0]        acc_cnt_r;
    logic [IDX_W-1:0]        pix_index_r;
    logic                    datastream_r;
    logic                    busy_r;
    logic                    frame_done_r;
    logic                    underrun_r;
    logic                    underrun_seen_r;

    logic                    pix_ready_s;
    logic                    accept_s;
    logic                    cur_bit_s;
    logic [BITS_PER_LED-1:0] shift_next_s;
    logic                    last_bit_s;
    logic                    last_pix_s;
    logic [BITS_PER_LED-1:0] next_word_s;
    logic                    have_next_s;
    logic                    tmr_load_s;
    logic [CNT_W-1:0]        tmr_len_s;
    logic                    tmr_expired_s;
    logic                    tmr_srst_s;

    // Handshake decode and phase-timer load selection, from registered state only
    always_comb begin
        pix_ready_s  = 1'b0;
        tmr_load_s   = 1'b0;
        tmr_len_s    = CNT_ZERO;
        cur_bit_s    = first_bit(shift_r);
        shift_next_s = shift_out(shift_r);
        last_bit_s   = (bit_cnt_r == BIT_LAST);
        last_pix_s   = (acc_cnt_r == ACC_FULL) && !buf_full_r;
        next_word_s  = buf_full_r ? buf_r : pix_data;
        tmr_srst_s   = (state_r == ST_IDLE);

        case (state_r)
            ST_FETCH: pix_ready_s = 1'b1;
            ST_HIGH,
            ST_LOW:   pix_ready_s = !buf_full_r && (acc_cnt_r < ACC_FULL);
            default:  pix_ready_s = 1'b0;
        endcase

        accept_s    = pix_valid && pix_ready_s;
        // A pixel arriving on the final edge of the last bit is used directly
        have_next_s = buf_full_r || accept_s;

        case (state_r)
            ST_FETCH: begin
                if (accept_s) begin
                    tmr_load_s = 1'b1;
                    tmr_len_s  = high_len(first_bit(pix_data));
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            ST_HIGH: begin
                if (tmr_expired_s) begin
                    tmr_load_s = 1'b1;
                    tmr_len_s  = low_len(cur_bit_s);
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            ST_LOW: begin
                if (tmr_expired_s) begin
                    tmr_load_s = 1'b1;
                    if (!last_bit_s) begin
                        tmr_len_s = high_len(first_bit(shift_next_s));
                    end else if (last_pix_s) begin
                        tmr_len_s = LEN_LATCH;
                    end else if (have_next_s) begin
                        tmr_len_s = high_len(first_bit(next_word_s));
                    end else begin
                        tmr_len_s = LEN_LATCH;
                    end
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            default: tmr_load_s = 1'b0;
        endcase
    end

    ws2812_bit_timer #(
        .CNT_W (CNT_W)
    ) u_bit_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .srst    (tmr_srst_s),
        .load    (tmr_load_s),
        .len     (tmr_len_s),
        .expired (tmr_expired_s)
    );

    // Frame sequencer: owns state, pixel buffers, counters and all outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            shift_r         <= WORD_ZERO;
            buf_r           <= WORD_ZERO;
            buf_full_r      <= 1'b0;
            bit_cnt_r       <= BIT_ZERO;
            acc_cnt_r       <= ACC_ZERO;
            pix_index_r     <= IDX_ZERO;
            datastream_r    <= 1'b0;
            busy_r          <= 1'b0;
            frame_done_r    <= 1'b0;
            underrun_r      <= 1'b0;
            underrun_seen_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            underrun_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    datastream_r <= 1'b0;
                    pix_index_r  <= IDX_ZERO;
                    acc_cnt_r    <= ACC_ZERO;
                    buf_full_r   <= 1'b0;
                    if (start) begin
                        state_r         <= ST_FETCH;
                        busy_r          <= 1'b1;
                        underrun_seen_r <= 1'b0;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (accept_s) begin
                        shift_r      <= pix_data;
                        bit_cnt_r    <= BIT_ZERO;
                        acc_cnt_r    <= acc_cnt_r + ACC_ONE;
                        pix_index_r  <= index_after(acc_cnt_r);
                        datastream_r <= 1'b1;
                        state_r      <= ST_HIGH;
                    end else begin
                        datastream_r <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (accept_s) begin
                        buf_r       <= pix_data;
                        buf_full_r  <= 1'b1;
                        acc_cnt_r   <= acc_cnt_r + ACC_ONE;
                        pix_index_r <= index_after(acc_cnt_r);
                    end
                    if (tmr_expired_s) begin
                        datastream_r <= 1'b0;
                        state_r      <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (accept_s) begin
                        buf_r       <= pix_data;
                        buf_full_r  <= 1'b1;
                        acc_cnt_r   <= acc_cnt_r + ACC_ONE;
                        pix_index_r <= index_after(acc_cnt_r);
                    end
                    if (tmr_expired_s) begin
                        if (!last_bit_s) begin
                            shift_r      <= shift_next_s;
                            bit_cnt_r    <= bit_cnt_r + BIT_ONE;
                            datastream_r <= 1'b1;
                            state_r      <= ST_HIGH;
                        end else if (last_pix_s) begin
                            state_r <= ST_LATCH;
                        end else if (have_next_s) begin
                            // Drain wins over a same-edge load: buffer ends empty
                            shift_r      <= next_word_s;
                            buf_full_r   <= 1'b0;
                            bit_cnt_r    <= BIT_ZERO;
                            datastream_r <= 1'b1;
                            state_r      <= ST_HIGH;
                        end else begin
                            underrun_r      <= 1'b1;
                            underrun_seen_r <= 1'b1;
                            state_r         <= ST_LATCH;
                        end
                    end
                end
                ST_LATCH: begin
                    datastream_r <= 1'b0;
                    if (tmr_expired_s) begin
                        state_r      <= ST_IDLE;
                        busy_r       <= 1'b0;
                        frame_done_r <= !underrun_seen_r;
                        acc_cnt_r    <= ACC_ZERO;
                        pix_index_r  <= IDX_ZERO;
                        buf_full_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    busy_r       <= 1'b0;
                    datastream_r <= 1'b0;
                end
            endcase
        end
    end

    assign pix_ready  = pix_ready_s;
    assign pix_index  = pix_index_r;
    assign datastream = datastream_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign underrun   = underrun_r;

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Directed bench for ws2812_frame_driver with short bit timings.
module tb_ws2812_frame_driver;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] pix_data = 24'h0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic        pix_index;
    logic        datastream, busy, frame_done, underrun;

    logic        start_l = 1'b0;
    logic [23:0] pix_data_l = 24'h000001;
    logic        pix_valid_l = 1'b1;
    logic        pix_ready_l, pix_index_l, ds_l, busy_l, fd_l, ur_l;

    int n_vec = 0;
    int n_err = 0;
    int fd_cnt = 0;
    int ur_cnt = 0;

    logic [23:0] feed_words [0:3];
    int          feed_len = 0;
    int          feed_ptr = 0;
    bit          feed_took = 1'b0;

    ws2812_frame_driver #(
        .NUM_LEDS(2), .BITS_PER_LED(24), .T0H_CYC(2), .T1H_CYC(4),
        .T0L_CYC(4), .T1L_CYC(2), .RESET_CYC(10), .MSB_FIRST(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_index(pix_index),
        .datastream(datastream), .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    ws2812_frame_driver #(
        .NUM_LEDS(2), .BITS_PER_LED(24), .T0H_CYC(2), .T1H_CYC(4),
        .T0L_CYC(4), .T1L_CYC(2), .RESET_CYC(10), .MSB_FIRST(0)
    ) dut_lsb (
        .clk(clk), .reset_n(reset_n), .start(start_l), .pix_data(pix_data_l),
        .pix_valid(pix_valid_l), .pix_ready(pix_ready_l), .pix_index(pix_index_l),
        .datastream(ds_l), .busy(busy_l), .frame_done(fd_l), .underrun(ur_l)
    );

    always #5 clk = ~clk;

    // Pixel source: presents feed_words in order, advancing after each handshake
    initial begin
        forever begin
            @(negedge clk);
            if (feed_took) feed_ptr++;
            pix_valid = (feed_ptr < feed_len);
            pix_data  = pix_valid ? feed_words[feed_ptr] : 24'h0;
            feed_took = pix_valid && pix_ready;
        end
    end

    // Pulse counters for the main instance
    initial begin
        forever begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (underrun)   ur_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic ds_of(input bit sel);
        return sel ? ds_l : datastream;
    endfunction

    // Waits for the next high pulse and returns its width in cycles
    task automatic measure_high(input bit sel, output int hi);
        int guard;
        guard = 0;
        while (ds_of(sel) == 1'b0 && guard < 200) begin tick(); guard++; end
        hi = 0;
        while (ds_of(sel) == 1'b1 && hi < 200) begin hi++; tick(); end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!frame_done && n < 2000) begin n++; tick(); end
        check_val(tag, frame_done, 1);
    endtask

    task automatic load_feed(input logic [23:0] w0, input logic [23:0] w1,
                             input logic [23:0] w2, input logic [23:0] w3, input int len);
        feed_words[0] = w0; feed_words[1] = w1; feed_words[2] = w2; feed_words[3] = w3;
        feed_len = len;
        feed_ptr = 0;
    endtask

    initial begin
        int          w, n, fd0, ur0;
        logic [23:0] word;
        logic        bp, hi_seen;

        // Reset state
        tick(); tick();
        check_val("rst_ds", datastream, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ready", pix_ready, 0);
        check_val("rst_index", pix_index, 0);
        check_val("rst_done", frame_done, 0);
        check_val("rst_underrun", underrun, 0);
        reset_n = 1'b1;
        tick(); tick();

        // A: bit timing of 0xA50000, MSB first
        word = 24'hA50000;
        load_feed(word, 24'h0, 24'h0, 24'h0, 2);
        start = 1'b1; tick(); start = 1'b0;
        check_val("a_busy", busy, 1);
        check_val("a_ready_fetch", pix_ready, 1);
        check_val("a_index0", pix_index, 0);
        check_val("a_ds_fetch", datastream, 0);
        for (int i = 0; i < 24; i++) begin
            measure_high(1'b0, w);
            check_val($sformatf("a_hi%0d", i), w, word[23-i] ? 4 : 2);
        end
        wait_done("a_done");

        // B: 0xFFFFFF then 0x000000 with valid held; gapless boundary, latch, done
        tick(); tick();
        fd0 = fd_cnt;
        load_feed(24'hFFFFFF, 24'h000000, 24'h0, 24'h0, 2);
        start = 1'b1; tick(); start = 1'b0;
        check_val("b_index0", pix_index, 0);
        for (int i = 0; i < 24; i++) begin
            measure_high(1'b0, w);
            check_val($sformatf("b_p0_hi%0d", i), w, 4);
            if (i == 0) begin
                check_val("b_index1", pix_index, 1);
                start = 1'b1; tick(); start = 1'b0;
            end
        end
        n = 0;
        while (datastream == 1'b0 && n < 100) begin n++; tick(); end
        check_val("b_gap_low", n, 2);
        for (int i = 0; i < 24; i++) begin
            measure_high(1'b0, w);
            check_val($sformatf("b_p1_hi%0d", i), w, 2);
        end
        n = 0; hi_seen = 1'b0; bp = busy;
        while (!frame_done && n < 100) begin
            if (datastream) hi_seen = 1'b1;
            bp = busy; n++; tick();
        end
        check_val("b_tail_low", n, 14);
        check_val("b_tail_quiet", hi_seen, 0);
        check_val("b_busy_before", bp, 1);
        check_val("b_busy_fall", busy, 0);
        check_val("b_index_idle", pix_index, 0);
        tick();
        check_val("b_done_1cyc", frame_done, 0);
        tick();
        check_val("b_start_ignored", busy, 0);
        check_val("b_done_count", fd_cnt - fd0, 1);

        // C: second pixel withheld -> underrun, latch, no frame_done
        fd0 = fd_cnt; ur0 = ur_cnt;
        load_feed(24'h000000, 24'h0, 24'h0, 24'h0, 1);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            measure_high(1'b0, w);
            check_val($sformatf("c_hi%0d", i), w, 2);
        end
        n = 0;
        while (!underrun && n < 100) begin n++; tick(); end
        check_val("c_underrun_at", n, 4);
        n = 0;
        while (busy && n < 100) begin n++; tick(); end
        check_val("c_latch_len", n, 10);
        check_val("c_no_done", frame_done, 0);
        tick();
        check_val("c_underrun_count", ur_cnt - ur0, 1);
        check_val("c_done_count", fd_cnt - fd0, 0);

        // D: reset during HIGH of bit 5, then a clean frame
        fd0 = fd_cnt; ur0 = ur_cnt;
        word = 24'h5A0000;
        load_feed(word, 24'h123456, 24'h0, 24'h0, 2);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            measure_high(1'b0, w);
            check_val($sformatf("d_hi%0d", i), w, word[23-i] ? 4 : 2);
        end
        n = 0;
        while (!datastream && n < 100) begin n++; tick(); end
        check_val("d_bit5_high", datastream, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("d_rst_ds", datastream, 0);
        check_val("d_rst_busy", busy, 0);
        check_val("d_rst_ready", pix_ready, 0);
        check_val("d_rst_index", pix_index, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check_val("d_rst_done", fd_cnt - fd0, 0);
        check_val("d_rst_underrun", ur_cnt - ur0, 0);
        load_feed(word, 24'h123456, 24'h0, 24'h0, 2);
        start = 1'b1; tick(); start = 1'b0;
        check_val("d_restart_busy", busy, 1);
        check_val("d_restart_index", pix_index, 0);
        measure_high(1'b0, w);
        check_val("d_restart_hi0", w, 2);
        wait_done("d_restart_done");
        tick();

        // F: start held high -> back-to-back frames with one IDLE cycle
        fd0 = fd_cnt;
        load_feed(24'h0, 24'h0, 24'h0, 24'h0, 4);
        start = 1'b1;
        wait_done("f_done1");
        check_val("f_idle_busy", busy, 0);
        tick();
        check_val("f_fetch_busy", busy, 1);
        check_val("f_fetch_ds", datastream, 0);
        tick();
        check_val("f_second_ds", datastream, 1);
        start = 1'b0;
        wait_done("f_done2");
        check_val("f_done_count", fd_cnt - fd0, 2);
        tick(); tick();
        check_val("f_stays_idle", busy, 0);

        // G: LSB-first instance, pixel 0x000001
        start_l = 1'b1; tick(); start_l = 1'b0;
        for (int i = 0; i < 24; i++) begin
            measure_high(1'b1, w);
            check_val($sformatf("g_hi%0d", i), w, (i == 0) ? 4 : 2);
        end
        n = 0;
        while (busy_l && n < 2000) begin n++; tick(); end
        check_val("g_idle", busy_l, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
